// File: rtl/alu_add_logic_pkg.sv
// Shared opcode encodings and status-flag bit positions for the add/logic execute slice.
package alu_add_logic_pkg;

   localparam logic [5:0] OP_ADD = 6'b000110;
   localparam logic [5:0] OP_AND = 6'b001011;
   localparam logic [5:0] OP_XOR = 6'b001110;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_add_logic_unit_add_flags_core.sv
// Combinational WIDTH-bit adder producing the sum and its {N,Z,C,V} flags.
module add_flags_core
   import alu_add_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o,
   output logic [3:0]       flags_o
);

   logic [WIDTH:0] sum_ext;

   always_comb begin
      sum_ext = {1'b0, a_i} + {1'b0, b_i};
      sum_o   = sum_ext[WIDTH-1:0];
      flags_o = '0;
      flags_o[FLAG_N] = sum_ext[WIDTH-1];
      flags_o[FLAG_Z] = (sum_ext[WIDTH-1:0] == '0);
      flags_o[FLAG_C] = sum_ext[WIDTH];
      // Overflow: like-signed operands producing a result of the other sign.
      flags_o[FLAG_V] = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
   end

endmodule

// File: rtl/alu_add_logic_unit.sv
// Registered ADD/AND/XOR execute slice with a 4-bit {N,Z,C,V} status register.
// Define ALU_LOGIC_FLAGS_EN to let AND/XOR with s=1 update the status register.
module alu_add_logic_unit
   import alu_add_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [5:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       cpsr,
   output logic             out_valid,
   output logic             op_err
);

   logic [WIDTH-1:0] sum;
   logic [3:0]       add_flags;
   logic [WIDTH-1:0] result_d, result_q;
   logic [3:0]       cpsr_d, cpsr_q;
   logic             out_valid_d, out_valid_q;
   logic             op_err_d, op_err_q;

   add_flags_core #(.WIDTH(WIDTH)) u_add_flags_core (
      .a_i    (a),
      .b_i    (b),
      .sum_o  (sum),
      .flags_o(add_flags)
   );

   always_comb begin
      result_d    = result_q;
      cpsr_d      = cpsr_q;
      op_err_d    = op_err_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         out_valid_d = 1'b1;
         op_err_d    = 1'b0;
         unique case (opcode)
            OP_ADD: begin
               result_d = sum;
               if (s) cpsr_d = add_flags;
            end
            OP_AND: result_d = a & b;
            OP_XOR: result_d = a ^ b;
            default: begin
               result_d = '0;
               op_err_d = 1'b1;
            end
         endcase
`ifdef ALU_LOGIC_FLAGS_EN
         if (s && (opcode == OP_AND || opcode == OP_XOR)) begin
            cpsr_d         = '0;
            cpsr_d[FLAG_N] = result_d[WIDTH-1];
            cpsr_d[FLAG_Z] = (result_d == '0);
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q    <= '0;
         cpsr_q      <= '0;
         out_valid_q <= 1'b0;
         op_err_q    <= 1'b0;
      end else begin
         result_q    <= result_d;
         cpsr_q      <= cpsr_d;
         out_valid_q <= out_valid_d;
         op_err_q    <= op_err_d;
      end
   end

   assign result    = result_q;
   assign cpsr      = cpsr_q;
   assign out_valid = out_valid_q;
   assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_add_logic_unit.sv
// Directed self-checking bench for alu_add_logic_unit (WIDTH=32).
module tb_alu_add_logic_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [5:0]  opcode = 6'b000110;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        s = 1'b0;
   logic [31:0] result;
   logic [3:0]  cpsr;
   logic        out_valid;
   logic        op_err;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

`ifdef ALU_LOGIC_FLAGS_EN
   localparam logic [3:0] CPSR_AND   = 4'b0000;
   localparam logic [3:0] CPSR_XOR   = 4'b0000;
   localparam logic [3:0] CPSR_XOR_Z = 4'b0100;
`else
   localparam logic [3:0] CPSR_AND   = 4'b1010;
   localparam logic [3:0] CPSR_XOR   = 4'b1010;
   localparam logic [3:0] CPSR_XOR_Z = 4'b1010;
`endif

   alu_add_logic_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .opcode   (opcode),
      .a        (a),
      .b        (b),
      .s        (s),
      .result   (result),
      .cpsr     (cpsr),
      .out_valid(out_valid),
      .op_err   (op_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic sv);
      in_valid = v;
      opcode   = op;
      a        = av;
      b        = bv;
      s        = sv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_all(input string tag, input logic [31:0] r, input logic [3:0] c,
                             input logic ov, input logic er);
      check({tag, ".result"}, {32'h0, result}, {32'h0, r});
      check({tag, ".cpsr"}, {60'h0, cpsr}, {60'h0, c});
      check({tag, ".out_valid"}, {63'h0, out_valid}, {63'h0, ov});
      check({tag, ".op_err"}, {63'h0, op_err}, {63'h0, er});
   endtask

   initial begin
      #2;
      expect_all("reset_init", 32'h0, 4'b0000, 1'b0, 1'b0);
      #6 rst = 1'b0;
      tick();

      // Overflow add, then asynchronous reset pulse between clock edges.
      drive(1'b1, 6'b000110, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      tick();
      expect_all("add_ovf_pre", 32'h8000_0000, 4'b1001, 1'b1, 1'b0);
      #1 rst = 1'b1;
      #1;
      expect_all("async_rst", 32'h0, 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b0, 6'b000110, 32'h0, 32'h0, 1'b0);
      tick();
      expect_all("post_rst_idle", 32'h0, 4'b0000, 1'b0, 1'b0);

      // Wrap to zero with carry.
      drive(1'b1, 6'b000110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      #1 check("wrap_latency", {63'h0, out_valid}, 64'h0);
      tick();
      expect_all("add_wrap", 32'h0, 4'b0110, 1'b1, 1'b0);

      drive(1'b1, 6'b000110, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      tick();
      expect_all("add_ovf", 32'h8000_0000, 4'b1001, 1'b1, 1'b0);

      drive(1'b1, 6'b000110, 32'd5, 32'd3, 1'b0);
      tick();
      expect_all("add_noflags", 32'h8, 4'b1001, 1'b1, 1'b0);

      drive(1'b1, 6'b000110, 32'h8000_0000, 32'h8000_0000, 1'b1);
      tick();
      expect_all("add_cv", 32'h0, 4'b0111, 1'b1, 1'b0);

      drive(1'b1, 6'b000110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      tick();
      expect_all("add_c_nov", 32'hFFFF_FFFE, 4'b1010, 1'b1, 1'b0);

      drive(1'b1, 6'b001011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1);
      tick();
      expect_all("and", 32'h00F0_00F0, CPSR_AND, 1'b1, 1'b0);

      drive(1'b1, 6'b001110, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1);
      tick();
      expect_all("xor", 32'h5555_5555, CPSR_XOR, 1'b1, 1'b0);

      drive(1'b1, 6'b001110, 32'h1234_5678, 32'h1234_5678, 1'b1);
      tick();
      expect_all("xor_zero", 32'h0, CPSR_XOR_Z, 1'b1, 1'b0);

      drive(1'b1, 6'b111111, 32'h1234_5678, 32'h1, 1'b1);
      tick();
      expect_all("bad_op", 32'h0, CPSR_XOR_Z, 1'b1, 1'b1);

      drive(1'b0, 6'b000110, 32'h1, 32'h1, 1'b1);
      tick();
      expect_all("idle_hold", 32'h0, CPSR_XOR_Z, 1'b0, 1'b1);

      drive(1'b1, 6'b001011, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
      tick();
      expect_all("err_clear", 32'h0F0F_0000, CPSR_XOR_Z, 1'b1, 1'b0);

      drive(1'b0, 6'b000110, 32'h0, 32'h0, 1'b0);
      tick();
      check("final_idle", {63'h0, out_valid}, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
